irq_pending_ctrl: RTL and testbench
===================================

# irq_pending_ctrl

Request-capture and sequencing stage placed directly upstream of the 4-to-2 priority encoder (`encoder4to2`). It edge-detects four request lines, holds them in a sticky pending register, and gates the masked pending vector into the encoder. It captures the encoder's winning index and presents it to a consumer over a valid/ack handshake with an acknowledge timeout. The encoder itself is instantiated beside this block; its `enable`, `d_in` and `y_out` connect to `enc_enable`, `enc_d_in` and `enc_y`.

## Interface
- `ACK_TIMEOUT`, default 15: maximum number of cycles `irq_valid` is held without acknowledge; legal range is ≥1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_in`  in  4  raw request lines, synchronous to `clk`; a rising edge sets the matching pending bit.
- `irq_mask`  in  4  1 = line enabled for arbitration.
- `enc_enable`  out  1  drives encoder `enable`.
- `enc_d_in`  out  4  drives encoder `d_in`; equals `pending & irq_mask` combinationally.
- `enc_y`  in  2  encoder `y_out`; index of the highest set bit of `enc_d_in` (bit 3 is highest priority).
- `irq_valid`  out  1  captured request index is valid.
- `irq_id`  out  2  captured request index.
- `irq_ack`  in  1  consumer acknowledge.
- `timeout`  out  1  one-cycle pulse when acknowledge times out.
- `pending`  out  4  sticky pending register.

## Operation
- Edge detect uses `rise = irq_in & ~irq_prev`, with `irq_prev` registered every cycle.
- Pending update each cycle is `pending <= (pending & ~clr) | rise`.
  - `clr` is one-hot of `irq_id` on an accepted ack, and 0 otherwise.
  - If set and clear hit the same bit in the same cycle, set wins.
- FSM states are IDLE, SAMPLE and WAIT_ACK.
  - **IDLE:** `enc_enable` = 0. If `pending & irq_mask` ≠ 0, go to SAMPLE.
  - **SAMPLE (one cycle):** `enc_enable` = 1.
    - If `pending & irq_mask` ≠ 0: `irq_id <= enc_y`, `irq_valid <= 1`, clear the timeout counter, go to WAIT_ACK.
    - Otherwise (mask removed in the meantime): go to IDLE with no valid.
  - **WAIT_ACK:** `irq_valid` = 1 and `enc_enable` = 0. The counter increments each cycle.
    - If `irq_ack` = 1: clear `pending[irq_id]`, `irq_valid <= 0`, go to IDLE.
    - Else if the counter reaches `ACK_TIMEOUT`−1: `irq_valid <= 0`, `timeout <= 1` for one cycle, keep the pending bit, go to IDLE (re-arbitrated later).
- `irq_ack` is ignored outside WAIT_ACK.
- `irq_id` holds its last value when `irq_valid` = 0.
- Mask changes during WAIT_ACK do not affect the outstanding `irq_id`.
- New edges during WAIT_ACK still set pending bits.
- The counter width is clog2(`ACK_TIMEOUT`+1).

## Timing
- Reset values:
  - `pending` = 0, `irq_prev` = 0, state = IDLE.
  - `enc_enable` = 0, `enc_d_in` = 0, `irq_valid` = 0, `irq_id` = 0, `timeout` = 0, counter = 0.
- A line that is already high when reset is released counts as a rising edge on the first cycle after reset.
- Latency:
  - Edge sampled at clock edge E0 sets `pending` after E0.
  - At E1 the FSM enters SAMPLE and `enc_enable` = 1.
  - At E2 `irq_valid` = 1 and `irq_id` is stable.
- Ack sampled at edge Ek: `irq_valid` = 0 and the pending bit is clear after Ek, and the FSM is in IDLE.
  - If another masked request is pending, `irq_valid` is high again 2 edges later.
- `irq_valid` stays high for at most `ACK_TIMEOUT` cycles.
  - An ack in the last of those cycles is accepted, and no timeout is raised.
- `timeout` is high for exactly one cycle, which is the first IDLE cycle.
- `rst` asserted in any state returns every register to its reset value at that edge, including while in SAMPLE or WAIT_ACK.
- The combinational paths are `irq_mask` → `enc_d_in` and `enc_y` → the `irq_id` register; there is no other input-to-output path.

## Test plan
- **Single request:** mask = 4'b1111; pulse `irq_in[1]` for 1 cycle; ack 1 cycle after valid.
  - Expect valid at the 2nd edge after sampling, `irq_id` = 1, `pending` back to 0000 after the ack.
- **Priority order:** pulse lines 0 and 2 in the same cycle; ack each grant immediately.
  - Expect grants in the order `irq_id` = 2 then 0, with valid re-asserting 2 edges after the first ack.
- **Masking:** mask = 4'b0111; pulse line 3 then line 1.
  - Expect only `irq_id` = 1 granted.
  - Then set mask = 4'b1111 and expect `irq_id` = 3 granted with `pending[3]` still set until its ack.
- **Timeout:** `ACK_TIMEOUT` = 4; pulse line 0 and never ack.
  - Expect valid high for 4 cycles, then `timeout` high 1 cycle with `pending[0]` still 1.
  - Expect the request re-granted 1 cycle later.
  - Ack in the 4th valid cycle → no timeout.
- **Set/clear collision:** while `irq_id` = 2 is valid, assert ack in the same cycle as a new rising edge on line 2.
  - Expect `pending[2]` = 1 after the edge and line 2 re-granted.
- **Reset mid-handshake:** assert `rst` for 1 cycle during WAIT_ACK.
  - Expect all outputs at reset values the next cycle.
  - A line held high across reset is re-detected and granted 2 edges after `rst` deasserts.

Source files
------------

// File: rtl/irq_pending_ctrl_if.sv
// Consumer-side handshake for irq_pending_ctrl: captured request index with valid/ack.
// The controller drives valid/id (master); the consumer returns ack (slave).
interface irq_pending_ctrl_if;
   logic       irq_valid;
   logic [1:0] irq_id;
   logic       irq_ack;

   modport master (
      output irq_valid,
      output irq_id,
      input  irq_ack
   );

   modport slave (
      input  irq_valid,
      input  irq_id,
      output irq_ack
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Edge-detecting sticky request capture ahead of a 4-to-2 priority encoder, presenting the
// encoder's winning index over a valid/ack handshake with an acknowledge timeout.
module irq_pending_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        i_irq_in,
   input  logic [3:0]        i_irq_mask,
   output logic              o_enc_enable,
   output logic [3:0]        o_enc_d_in,
   input  logic [1:0]        i_enc_y,
   output logic              o_timeout,
   output logic [3:0]        o_pending,
   irq_pending_ctrl_if.master bus
);

   localparam int unsigned   CntW    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(ACK_TIMEOUT - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StSample  = 2'd1,
      StWaitAck = 2'd2
   } state_e;

   state_e          r_state;
   state_e          w_state_next;

   logic [3:0]      r_irq_prev;
   logic [3:0]      r_pending;
   logic [1:0]      r_irq_id;
   logic            r_irq_valid;
   logic            r_timeout;
   logic [CntW-1:0] r_cnt;

   logic [3:0]      w_rise;
   logic [3:0]      w_masked;
   logic            w_any;
   logic            w_ack_ok;
   logic            w_expire;
   logic [3:0]      w_clr;

   assign w_rise   = i_irq_in & ~r_irq_prev;
   assign w_masked = r_pending & i_irq_mask;
   assign w_any    = |w_masked;
   assign w_ack_ok = (r_state == StWaitAck) && bus.irq_ack;
   // An ack in the final valid cycle takes precedence over the timeout.
   assign w_expire = (r_state == StWaitAck) && !bus.irq_ack && (r_cnt == CntLast);

   always_comb begin
      w_clr = 4'b0000;
      if (w_ack_ok) begin
         w_clr[r_irq_id] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_any) begin
               w_state_next = StSample;
            end
         end
         StSample: begin
            w_state_next = w_any ? StWaitAck : StIdle;
         end
         StWaitAck: begin
            if (w_ack_ok || w_expire) begin
               w_state_next = StIdle;
            end
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Output logic
   always_comb begin
      o_enc_enable = (r_state == StSample);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq_prev  <= 4'b0000;
         r_pending   <= 4'b0000;
         r_irq_id    <= 2'd0;
         r_irq_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_irq_prev <= i_irq_in;
         // Set wins over clear on the same bit.
         r_pending  <= (r_pending & ~w_clr) | w_rise;
         r_timeout  <= w_expire;
         case (r_state)
            StSample: begin
               if (w_any) begin
                  r_irq_id    <= i_enc_y;
                  r_irq_valid <= 1'b1;
                  r_cnt       <= '0;
               end
            end
            StWaitAck: begin
               if (w_ack_ok || w_expire) begin
                  r_irq_valid <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CntOne;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_enc_d_in    = w_masked;
   assign o_pending     = r_pending;
   assign o_timeout     = r_timeout;
   assign bus.irq_valid = r_irq_valid;
   assign bus.irq_id    = r_irq_id;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Randomized and directed bench for irq_pending_ctrl against a cycle-level behavioural model,
// with a behavioural priority encoder closing the enc_d_in -> enc_y loop.
module tb_irq_pending_ctrl;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] irq_in;
   logic [3:0] irq_mask;
   logic       enc_enable;
   logic [3:0] enc_d_in;
   logic [1:0] enc_y;
   logic       timeout;
   logic [3:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   irq_pending_ctrl_if u_if ();

   irq_pending_ctrl #(
      .ACK_TIMEOUT(T)
   ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .i_irq_in     (irq_in),
      .i_irq_mask   (irq_mask),
      .o_enc_enable (enc_enable),
      .o_enc_d_in   (enc_d_in),
      .i_enc_y      (enc_y),
      .o_timeout    (timeout),
      .o_pending    (pending),
      .bus          (u_if)
   );

   always #5 clk = ~clk;

   // Priority encoder beside the block: highest set bit wins.
   always_comb begin
      enc_y = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (enc_d_in[i]) enc_y = 2'(i);
      end
   end

   // Reference model: phase 0 = quiet, 1 = arbitrating, 2 = grant outstanding.
   int m_pend, m_prev, m_id, m_valid, m_vcycles, m_to, m_phase, m_mask;

   function automatic int top_bit(input int v);
      for (int i = 3; i >= 0; i--) begin
         if (((v >> i) & 1) != 0) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_prev = 0; m_id = 0; m_valid = 0; m_vcycles = 0; m_to = 0; m_phase = 0;
   endtask

   task automatic model_step(input int in, input int mask, input int ack, input int r);
      int rise, masked, clr, ph, to_n;
      m_mask = mask;
      if (r != 0) begin
         model_reset();
         return;
      end
      rise   = in & ~m_prev & 15;
      masked = m_pend & mask;
      clr    = 0;
      to_n   = 0;
      ph     = m_phase;
      if (m_phase == 2 && ack != 0) clr = 1 << m_id;
      case (m_phase)
         0: if (masked != 0) ph = 1;
         1: begin
            if (masked != 0) begin
               m_id = top_bit(masked); m_valid = 1; m_vcycles = 1; ph = 2;
            end else begin
               ph = 0;
            end
         end
         default: begin
            if (ack != 0) begin
               m_valid = 0; ph = 0;
            end else if (m_vcycles == T) begin
               m_valid = 0; to_n = 1; ph = 0;
            end else begin
               m_vcycles++;
            end
         end
      endcase
      m_pend  = ((m_pend & ~clr) | rise) & 15;
      m_prev  = in;
      m_to    = to_n;
      m_phase = ph;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      check_eq("pending",    32'(pending),    32'(m_pend));
      check_eq("irq_valid",  32'(u_if.irq_valid), 32'(m_valid));
      check_eq("irq_id",     32'(u_if.irq_id),    32'(m_id));
      check_eq("timeout",    32'(timeout),    32'(m_to));
      check_eq("enc_enable", 32'(enc_enable), 32'(m_phase == 1));
      check_eq("enc_d_in",   32'(enc_d_in),   32'(m_pend & m_mask));
   endtask

   task automatic step(input logic [3:0] in, input logic [3:0] mask, input logic ack,
                       input logic r);
      irq_in       = in;
      irq_mask     = mask;
      u_if.irq_ack = ack;
      rst          = r;
      @(posedge clk);
      model_step(int'(in), int'(mask), int'(ack), int'(r));
      @(negedge clk);
      check_all();
   endtask

   initial begin
      model_reset();
      m_mask = 0;
      irq_in = 4'h0; irq_mask = 4'h0; u_if.irq_ack = 1'b0; rst = 1'b1;

      // Reset state
      step(4'h0, 4'h0, 1'b0, 1'b1);
      step(4'h0, 4'h0, 1'b0, 1'b1);
      check_eq("reset_pending", 32'(pending), 32'd0);
      check_eq("reset_valid", 32'(u_if.irq_valid), 32'd0);

      // Single request on line 1, ack one cycle after valid
      step(4'h2, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("single_sample", 32'(enc_enable), 32'd1);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("single_valid", 32'(u_if.irq_valid), 32'd1);
      check_eq("single_id", 32'(u_if.irq_id), 32'd1);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b1, 1'b0);
      check_eq("single_cleared", 32'(pending), 32'd0);

      // Priority: lines 0 and 2 together
      step(4'h5, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("prio_first", 32'(u_if.irq_id), 32'd2);
      step(4'h0, 4'hf, 1'b1, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("prio_second", 32'(u_if.irq_id), 32'd0);
      check_eq("prio_second_valid", 32'(u_if.irq_valid), 32'd1);
      step(4'h0, 4'hf, 1'b1, 1'b0);

      // Masking: line 3 masked off, line 1 granted, then line 3 after unmasking
      step(4'h8, 4'h7, 1'b0, 1'b0);
      step(4'h2, 4'h7, 1'b0, 1'b0);
      step(4'h0, 4'h7, 1'b0, 1'b0);
      step(4'h0, 4'h7, 1'b0, 1'b0);
      check_eq("mask_id", 32'(u_if.irq_id), 32'd1);
      step(4'h0, 4'h7, 1'b1, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("unmask_id", 32'(u_if.irq_id), 32'd3);
      check_eq("unmask_pend", 32'(pending), 32'h8);
      step(4'h0, 4'hf, 1'b1, 1'b0);

      // Timeout: never ack line 0
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      for (int i = 0; i < T; i++) step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("to_last_valid", 32'(u_if.irq_valid), 32'd1);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("to_pulse", 32'(timeout), 32'd1);
      check_eq("to_pend_kept", 32'(pending), 32'h1);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("to_regrant", 32'(u_if.irq_valid), 32'd1);
      // Ack in the final valid cycle is accepted without timeout
      for (int i = 0; i < T - 1; i++) step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b1, 1'b0);
      check_eq("late_ack_no_to", 32'(timeout), 32'd0);
      check_eq("late_ack_clear", 32'(pending), 32'd0);

      // Set/clear collision on line 2
      step(4'h4, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h4, 4'hf, 1'b1, 1'b0);
      check_eq("collide_pend", 32'(pending), 32'h4);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      step(4'h0, 4'hf, 1'b0, 1'b0);
      check_eq("collide_regrant", 32'(u_if.irq_id), 32'd2);
      step(4'h0, 4'hf, 1'b1, 1'b0);

      // Reset mid-handshake with line 0 held high across reset
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h1, 4'hf, 1'b0, 1'b1);
      check_eq("rst_mid_valid", 32'(u_if.irq_valid), 32'd0);
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h1, 4'hf, 1'b0, 1'b0);
      step(4'h1, 4'hf, 1'b0, 1'b0);
      check_eq("rst_redetect", 32'(u_if.irq_valid), 32'd1);
      step(4'h0, 4'hf, 1'b1, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] in_r, mask_r;
         logic       ack_r, rst_r;
         in_r   = 4'($urandom) & 4'($urandom);
         mask_r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
         ack_r  = ($urandom_range(0, 9) < 3);
         rst_r  = ($urandom_range(0, 199) == 0);
         step(in_r, mask_r, ack_r, rst_r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
